// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with per-register busy scoreboard.
// Register 0 reads as zero and is never busy; optional same-cycle write bypass.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned INIT_CNT = 8,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_wn,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_ok, iss_ok, set_new, clr_real;

    assign wr_ok  = we && (wn != '0);
    assign iss_ok = iss_we && (iss_wn != '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[wn] = 1'b0;
        // Issue applied last so a new producer supersedes a retiring one.
        if (iss_ok) busy_d[iss_wn] = 1'b1;
    end

    // Incremental count: only transitions 0->1 and 1->0 move it.
    always_comb begin
        set_new  = iss_ok && !busy_q[iss_wn];
        clr_real = wr_ok && busy_q[wn] && !(iss_ok && (iss_wn == wn));
        cnt_d    = cnt_q;
        if (set_new && !clr_real) begin
            cnt_d = cnt_q + (ADDR_W + 1)'(1);
        end else if (!set_new && clr_real) begin
            cnt_d = cnt_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i >= 1 && i <= INIT_CNT) ? DATA_W'(i) : '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) regs_q[wn] <= d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        qa     = regs_q[rna];
        busy_a = busy_q[rna];
        if (BYPASS != 0 && wr_ok && (wn == rna)) begin
            qa = d;
            if (!(iss_ok && (iss_wn == rna))) busy_a = 1'b0;
        end
        if (rna == '0) begin
            qa     = '0;
            busy_a = 1'b0;
        end
    end

    always_comb begin
        qb     = regs_q[rnb];
        busy_b = busy_q[rnb];
        if (BYPASS != 0 && wr_ok && (wn == rnb)) begin
            qb = d;
            if (!(iss_ok && (iss_wn == rnb))) busy_b = 1'b0;
        end
        if (rnb == '0) begin
            qb     = '0;
            busy_b = 1'b0;
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one bypassing and one non-bypassing instance
// driven in lockstep; expected values queued per cycle and checked at negedge.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        clrn, we, iss_we;
    logic [4:0]  rna, rnb, wn, iss_wn;
    logic [31:0] d;
    logic [31:0] qa, qb, qa0, qb0;
    logic        busy_a, busy_b, busy_a0, busy_b0;
    logic [5:0]  busy_cnt, busy_cnt0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .INIT_CNT(8), .BYPASS(1)) dut (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .busy_a(busy_a), .busy_b(busy_b), .we(we), .wn(wn), .d(d),
        .iss_we(iss_we), .iss_wn(iss_wn), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .INIT_CNT(8), .BYPASS(0)) dut0 (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .busy_a(busy_a0), .busy_b(busy_b0), .we(we), .wn(wn), .d(d),
        .iss_we(iss_we), .iss_wn(iss_wn), .busy_cnt(busy_cnt0)
    );

    // chk bits: 0 qa, 1 qb, 2 busy_a, 3 busy_b, 4 qa (no bypass), 5 busy_a (no bypass)
    typedef struct {
        int          id;
        logic [5:0]  chk;
        logic [31:0] qa, qb, qa0;
        logic        ba, bb, ba0;
        logic        cnt_chk;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] busy_m;
    logic        model_valid = 1'b0;
    int          cyc_id = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input int id, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk[0]) check(mon_e.id, "qa", qa, mon_e.qa);
            if (mon_e.chk[1]) check(mon_e.id, "qb", qb, mon_e.qb);
            if (mon_e.chk[2]) check(mon_e.id, "busy_a", 32'(busy_a), 32'(mon_e.ba));
            if (mon_e.chk[3]) check(mon_e.id, "busy_b", 32'(busy_b), 32'(mon_e.bb));
            if (mon_e.chk[4]) check(mon_e.id, "qa_nobyp", qa0, mon_e.qa0);
            if (mon_e.chk[5]) check(mon_e.id, "busy_a_nobyp", 32'(busy_a0), 32'(mon_e.ba0));
            if (mon_e.cnt_chk) begin
                check(mon_e.id, "busy_cnt", 32'(busy_cnt), 32'(mon_e.cnt));
                check(mon_e.id, "busy_cnt_nobyp", 32'(busy_cnt0), 32'(mon_e.cnt));
            end
        end
    end

    // One cycle: drive inputs after the edge, queue expectations for this cycle,
    // then advance the busy model to the state after the coming edge.
    task automatic cyc(input logic c, input logic w, input logic [4:0] wn_,
                       input logic [31:0] d_, input logic iw, input logic [4:0] iwn,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [5:0] chk,
                       input logic [31:0] eqa, input logic [31:0] eqb,
                       input logic [31:0] eqa0, input logic eba, input logic ebb,
                       input logic eba0);
        exp_t e;
        @(posedge clk);
        #1;
        clrn = c; we = w; wn = wn_; d = d_; iss_we = iw; iss_wn = iwn; rna = ra; rnb = rb;
        e.id = cyc_id; e.chk = chk; e.qa = eqa; e.qb = eqb; e.qa0 = eqa0;
        e.ba = eba; e.bb = ebb; e.ba0 = eba0;
        e.cnt_chk = model_valid;
        e.cnt = 6'($countones(busy_m));
        sb_q.push_back(e);
        cyc_id++;
        if (!c) begin
            busy_m = '0;
        end else begin
            if (w && wn_ != 0) busy_m[wn_] = 1'b0;
            if (iw && iwn != 0) busy_m[iwn] = 1'b1;
        end
        busy_m[0] = 1'b0;
        if (!c) model_valid = 1'b1;
    endtask

    initial begin
        clrn = 1'b0; we = 1'b0; wn = '0; d = '0; iss_we = 1'b0; iss_wn = '0;
        rna = '0; rnb = '0; busy_m = '0;
        //  c  w  wn  d             iw iwn ra rb chk        qa            qb            qa0
        cyc(0, 0, 0, 32'h0,        0, 0, 5, 9, 6'b000000, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 5, 9, 6'b011111, 5, 0, 5, 0, 0, 0);
        cyc(1, 1, 3, 32'hDEADBEEF, 0, 0, 3, 0, 6'b010001, 32'hDEADBEEF, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 3, 0, 6'b010001, 32'hDEADBEEF, 0,
            32'hDEADBEEF, 0, 0, 0);
        cyc(1, 1, 0, 32'h1234,     0, 0, 0, 0, 6'b010111, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b010001, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 6'b010011, 32'hA5A5A5A5, 32'hA5A5A5A5,
            7, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 7, 7, 6'b010001, 32'hA5A5A5A5, 0,
            32'hA5A5A5A5, 0, 0, 0);
        // Scoreboard: issue is not bypassed, writeback clear is.
        cyc(1, 0, 0, 32'h0,        1, 4, 4, 0, 6'b000100, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 4, 0, 6'b100100, 0, 0, 0, 1, 0, 1);
        cyc(1, 1, 4, 32'h44,       0, 0, 4, 0, 6'b100101, 32'h44, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 32'h0,        0, 0, 4, 0, 6'b100101, 32'h44, 0, 0, 0, 0, 0);
        // Same-index set and clear: set wins.
        cyc(1, 0, 0, 32'h0,        1, 6, 6, 0, 6'b000100, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 32'h66,       1, 6, 6, 0, 6'b100101, 32'h66, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 32'h0,        0, 0, 6, 0, 6'b010101, 32'h66, 0, 32'h66, 1, 0, 0);
        // Set 2 while clearing busy 6.
        cyc(1, 1, 6, 32'h67,       1, 2, 2, 6, 6'b101100, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 2, 6, 6'b001110, 0, 32'h67, 0, 1, 0, 0);
        cyc(1, 0, 0, 32'h0,        1, 2, 2, 0, 6'b000100, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 9, 32'h99,       0, 0, 2, 9, 6'b001110, 0, 32'h99, 0, 1, 0, 0);
        // Build busy {1,2,3} with reg[1]=FF, then reset alongside an issue to 5.
        cyc(1, 1, 1, 32'hFF,       1, 1, 1, 9, 6'b010111, 32'hFF, 32'h99, 1, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        1, 3, 1, 0, 6'b010101, 32'hFF, 0, 32'hFF, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        1, 5, 1, 3, 6'b001101, 32'hFF, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 1, 5, 6'b011111, 1, 5, 1, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 2, 3, 6'b001111, 2, 3, 0, 0, 0, 0);
        // Index 0 is never written nor busy.
        cyc(1, 1, 0, 32'h55,       1, 0, 0, 0, 6'b000101, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b010101, 0, 0, 0, 0, 0, 0);
        // Fill every busy bit to reach the maximum count, then drain.
        for (int i = 1; i < 32; i++) begin
            cyc(1, 0, 0, 32'h0, 1, 5'(i), 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 32'h0,        0, 0, 31, 0, 6'b000100, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i < 32; i++) begin
            cyc(1, 1, 5'(i), 32'(i), 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 32'h0,        0, 0, 31, 0, 6'b010101, 31, 0, 31, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline CPU's 2-read/1-write register file.
- Generalises data width and register count.
- Writes on the rising clock edge, with an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: the ID stage sets a bit when it issues a producing instruction, and WB clears it on writeback. The hazard unit reads busy bits for both source operands.
- Sits between the ID and WB stages and replaces the fixed 32x32 file.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W; register 0 is hardwired to zero.
- INIT_CNT, 8, registers 1..INIT_CNT reset to their own index value; all others reset to 0.
- BYPASS, 1, 1 = read ports return d when a write targets the same index in that cycle; 0 = read returns the old value until the next cycle.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clrn  in  1  reset, synchronous and active-low.
- rna  in  ADDR_W  read port A index.
- rnb  in  ADDR_W  read port B index.
- qa  out  DATA_W  read data A (combinational).
- qb  out  DATA_W  read data B (combinational).
- busy_a  out  1  scoreboard bit for rna (combinational).
- busy_b  out  1  scoreboard bit for rnb (combinational).
- we  in  1  writeback enable.
- wn  in  ADDR_W  writeback index.
- d  in  DATA_W  writeback data.
- iss_we  in  1  issue: mark iss_wn busy.
- iss_wn  in  ADDR_W  issue destination index.
- busy_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (clrn=0 at a rising edge):
  - reg[i] = i for 1 <= i <= INIT_CNT, else 0.
  - All busy bits = 0; busy_cnt = 0.
  - Reset overrides any we or iss_we in the same cycle.
  - Asserting reset mid-sequence discards pending busy state.
- Reads:
  - Combinational, zero latency.
  - Index 0 returns 0 and busy 0, regardless of writes or bypass.
- Writes:
  - When we=1 and wn!=0, reg[wn] <= d at the rising edge.
  - wn=0 is ignored.
- Bypass (BYPASS=1): if we=1, wn!=0 and rna==wn, then qa = d in the same cycle. Same rule for qb.
- Busy bits:
  - Writeback with we=1, wn!=0 clears busy[wn] at the edge.
  - Issue with iss_we=1, iss_wn!=0 sets busy[iss_wn] at the edge.
  - iss_wn=0 is ignored.
  - Set and clear of the same index in one cycle: set wins; the new producer supersedes the retiring one.
  - Setting an already-busy bit leaves it 1; no nesting or counting per register.
  - Clearing a non-busy bit leaves it 0; no error.
- Busy bypass (BYPASS=1): busy_a reflects the pending clear, so it reads 0 when a writeback to rna occurs this cycle, unless an issue to rna also occurs this cycle. Pending issues are not bypassed; busy_a rises the cycle after the issue. Same rule for busy_b. With BYPASS=0, busy outputs show the registered state only.
- busy_cnt:
  - Equals the population count of the busy vector after each edge.
  - Updated incrementally: +1 on a valid set of a non-busy bit, -1 on a valid clear of a busy bit that is not simultaneously set, net 0 when both happen on different indices with those conditions.
  - Must always equal the popcount; the bench checks this every cycle.
  - Maximum value 2**ADDR_W - 1; register 0 is never counted.
- No X propagation: all storage is defined after the first reset edge.

Test Plan:
- Reset with DATA_W=32, INIT_CNT=8, clrn=0 for one edge:
  - rna=5 gives qa=5; rnb=9 gives qb=0.
  - busy_a = busy_b = 0; busy_cnt = 0.
- Write, then read:
  - we=1, wn=3, d=0xDEADBEEF; next cycle rna=3 -> qa=0xDEADBEEF.
  - we=1, wn=0, d=0x1234; rna=0 -> qa=0 both that cycle and the next.
- Bypass with BYPASS=1: we=1, wn=7, d=0xA5A5A5A5, rna=rnb=7 -> qa=qb=0xA5A5A5A5 in the same cycle. With BYPASS=0 and reg[7]=7 after reset, the same stimulus gives qa=7 that cycle and 0xA5A5A5A5 the next.
- Scoreboard:
  - Issue iss_wn=4 -> busy_a=1 for rna=4 one cycle later; busy_cnt=1.
  - Writeback we=1, wn=4 -> busy_a=0 in the same cycle (BYPASS=1); busy_cnt=0 after the edge.
- Simultaneous events:
  - With busy[6]=1, iss_wn=6 and wn=6 in the same cycle -> busy[6] stays 1 and busy_cnt is unchanged.
  - iss_wn=2 with wn=6 (busy) in the same cycle -> busy_cnt unchanged, busy[2]=1, busy[6]=0.
- Reset mid-operation:
  - Set busy on 1, 2 and 3 (busy_cnt=3) and write reg[1]=0xFF.
  - Assert clrn=0 while iss_we=1, iss_wn=5 -> after the edge, busy_cnt=0, all busy bits 0, reg[1]=1, reg[5]=5.
